// File: rtl/data_sram_responder.sv
// Byte-writable single-port data memory answering the execute stage, with 1-cycle read latency.
// Defining DSRAM_CLEAR_ON_RESET_EN adds a post-reset sequencer that zeroes every word before sram_ready rises.
module data_sram_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        sram_ready,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          ready_int;
    logic          access;
    logic          acc_write;
    logic          acc_read;
    logic          oor_access;
    logic          oor_read;
    logic          unused_addr_bits;

    // Below-base addresses wrap to a huge offset, so one upper-bits test covers both ends.
    assign offset           = data_sram_addr - BASE_ADDR;
    assign word_idx         = offset[AW+1:2];
    assign in_range         = (offset[31:AW+2] == '0);
    assign unused_addr_bits = ^offset[1:0];

    assign access     = data_sram_en && ready_int && !reset;
    assign acc_write  = access && in_range && (data_sram_wen != 4'b0000);
    assign acc_read   = access && in_range && (data_sram_wen == 4'b0000);
    assign oor_access = access && !in_range;
    assign oor_read   = oor_access && (data_sram_wen == 4'b0000);

    logic [3:0]    lane_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

`ifdef DSRAM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        CLEAR      = 2'd1,
        READY      = 2'd2
    } clr_state_t;

    clr_state_t    state_q;
    logic [AW-1:0] clr_ptr_q;
    logic          sram_ready_q;

    // Clear walks words 0..DEPTH-1, one per cycle; ready is raised on the edge that writes the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_HOLD;
            clr_ptr_q    <= '0;
            sram_ready_q <= 1'b0;
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    state_q   <= CLEAR;
                    clr_ptr_q <= '0;
                end
                CLEAR: begin
                    if (clr_ptr_q == {AW{1'b1}}) begin
                        state_q      <= READY;
                        sram_ready_q <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                READY: begin
                    sram_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= RESET_HOLD;
                    sram_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_int = sram_ready_q;
`else
    assign ready_int = 1'b1;
`endif

    always_comb begin
        lane_we   = acc_write ? data_sram_wen : 4'b0000;
        mem_waddr = word_idx;
        mem_wdata = data_sram_wdata;
`ifdef DSRAM_CLEAR_ON_RESET_EN
        if (state_q == CLEAR && !reset) begin
            lane_we   = 4'b1111;
            mem_waddr = clr_ptr_q;
            mem_wdata = 32'h0000_0000;
        end
`endif
    end

    // One byte-wide array per lane keeps each lane a simple RAM with its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rdata_q;

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[mem_waddr] <= mem_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (reset || oor_read) begin
                    lane_rdata_q <= 8'h00;
                end else if (acc_read) begin
                    lane_rdata_q <= lane_mem[word_idx];
                end
            end

            assign data_sram_rdata[8*gi +: 8] = lane_rdata_q;
        end
    endgenerate

    logic [31:0] rd_cnt_d, rd_cnt_q;
    logic [31:0] wr_cnt_d, wr_cnt_q;
    logic        addr_err_d, addr_err_q;

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        addr_err_d = oor_access;
        if (acc_read && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (acc_write && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q   <= 32'd0;
            wr_cnt_q   <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;
    assign addr_err   = addr_err_q;
    assign sram_ready = ready_int;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised self-checking bench for data_sram_responder against a word-array reference model.
module tb_data_sram_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        sram_ready;
    logic        addr_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    data_sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .sram_ready(sram_ready),
        .addr_err(addr_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: word array, expected outputs, cycles since reset released.
    logic [31:0] mmem [DEPTH];
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    logic [31:0] exp_wr = 32'h0;
    logic        model_ready = 1'b0;
    int          since = 0;

    task automatic step(input logic rst, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off;
        @(negedge clk);
        reset = rst; data_sram_en = en; data_sram_wen = wen;
        data_sram_addr = addr; data_sram_wdata = wd;
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b en=%0b wen=%h addr=%h wdata=%h -> rdata=%h err=%0b rd=%0d wr=%0d rdy=%0b",
                 $time, rst, en, wen, addr, wd, data_sram_rdata, addr_err, rd_cnt, wr_cnt, sram_ready);
        off = addr - BASE;
        if (rst) begin
            exp_rdata = 32'h0; exp_err = 1'b0; exp_rd = 32'h0; exp_wr = 32'h0; since = 0;
`ifdef DSRAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
`endif
        end else begin
            exp_err = 1'b0;
            if (en && model_ready) begin
                if (off >= 32'(DEPTH * 4)) begin
                    exp_err = 1'b1;
                    if (wen == 4'h0) exp_rdata = 32'h0;
                end else if (wen != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (wen[b]) mmem[off / 4][8*b +: 8] = wd[8*b +: 8];
                    if (exp_wr != 32'hFFFF_FFFF) exp_wr = exp_wr + 1;
                end else begin
                    exp_rdata = mmem[off / 4];
                    if (exp_rd != 32'hFFFF_FFFF) exp_rd = exp_rd + 1;
                end
            end
            if (since < 1000) since++;
        end
`ifdef DSRAM_CLEAR_ON_RESET_EN
        model_ready = (since >= DEPTH + 1);
`else
        model_ready = 1'b1;
`endif
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0);
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0);
`ifdef DSRAM_CLEAR_ON_RESET_EN
        repeat (DEPTH + 1) step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
`endif
    endtask

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b0, 4'h0, BASE, 32'h0);
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", data_sram_rdata, 32'h0); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", addr_err); end
        total++; if (rd_cnt !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rd_cnt); end
        total++; if (wr_cnt !== 32'h0) begin bad++; $display("FAIL reset_wr got=%h exp=0", wr_cnt); end
`ifdef DSRAM_CLEAR_ON_RESET_EN
        total++; if (sram_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", sram_ready); end
`else
        total++; if (sram_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", sram_ready); end
`endif
    endtask

`ifdef DSRAM_CLEAR_ON_RESET_EN
    task automatic test_clear_sequence();
        for (int c = 1; c <= 7; c++) begin
            step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
            total++; if (sram_ready !== 1'b0) begin bad++; $display("FAIL clr_early_ready c=%0d got=%b exp=0", c, sram_ready); end
        end
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0);
        for (int c = 1; c <= DEPTH + 1; c++) begin
            step(1'b0, (c == 5), 4'hF, BASE + 32'd12, 32'hFFFF_FFFF);
            total++; if (sram_ready !== (c >= DEPTH + 1)) begin bad++; $display("FAIL clr_ready c=%0d got=%b exp=%b", c, sram_ready, (c >= DEPTH + 1)); end
        end
        total++; if (wr_cnt !== 32'h0) begin bad++; $display("FAIL clr_wr_ignored got=%h exp=0", wr_cnt); end
        step(1'b0, 1'b1, 4'h0, BASE, 32'h0);
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL clr_word0 got=%h exp=0", data_sram_rdata); end
        step(1'b0, 1'b1, 4'h0, BASE + 32'(4 * (DEPTH - 1)), 32'h0);
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL clr_word15 got=%h exp=0", data_sram_rdata); end
        step(1'b0, 1'b1, 4'h0, BASE + 32'd12, 32'h0);
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL clr_word3 got=%h exp=0", data_sram_rdata); end
    endtask
`endif

    task automatic test_full_word();
        do_reset();
        step(1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL full_hold_on_write got=%h exp=0", data_sram_rdata); end
        step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        total++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL full_rdata got=%h exp=DEADBEEF", data_sram_rdata); end
        total++; if (rd_cnt !== 32'd1) begin bad++; $display("FAIL full_rd_cnt got=%0d exp=1", rd_cnt); end
        total++; if (wr_cnt !== 32'd1) begin bad++; $display("FAIL full_wr_cnt got=%0d exp=1", wr_cnt); end
    endtask

    task automatic test_byte_lanes();
        step(1'b0, 1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344);
        total++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lanes_hold got=%h exp=DEADBEEF", data_sram_rdata); end
        step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        total++; if (data_sram_rdata !== 32'hDE22_BE44) begin bad++; $display("FAIL lanes_rdata got=%h exp=DE22BE44", data_sram_rdata); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] wr_before;
        logic [31:0] rd_before;
        step(1'b0, 1'b1, 4'hF, BASE + 32'(4 * (DEPTH - 1)), $urandom);
        rd_before = exp_rd;
        step(1'b0, 1'b1, 4'h0, BASE + 32'(DEPTH * 4), 32'h0);
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", data_sram_rdata); end
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_err_pulse got=%b exp=1", addr_err); end
        total++; if (rd_cnt !== rd_before) begin bad++; $display("FAIL oor_rd_cnt got=%0d exp=%0d", rd_cnt, rd_before); end
        step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_one_cycle got=%b exp=0", addr_err); end
        wr_before = exp_wr;
        step(1'b0, 1'b1, 4'hF, BASE - 32'd4, 32'hBAD0_BAD0);
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b exp=1", addr_err); end
        total++; if (wr_cnt !== wr_before) begin bad++; $display("FAIL oor_wr_cnt got=%0d exp=%0d", wr_cnt, wr_before); end
        step(1'b0, 1'b1, 4'h0, BASE + 32'(4 * (DEPTH - 1)), 32'h0);
        total++; if (data_sram_rdata !== exp_rdata) begin bad++; $display("FAIL oor_mem_unchanged got=%h exp=%h", data_sram_rdata, exp_rdata); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_clear got=%b exp=0", addr_err); end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 4'($urandom), BASE + 32'h10, $urandom);
            total++; if (data_sram_rdata !== 32'hDE22_BE44) begin bad++; $display("FAIL hold_rdata c=%0d got=%h exp=DE22BE44", c, data_sram_rdata); end
        end
        step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        total++; if (data_sram_rdata !== exp_rdata) begin bad++; $display("FAIL hold_no_write got=%h exp=%h", data_sram_rdata, exp_rdata); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.rd_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_cnt_q;
        exp_rd = 32'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
            total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL sat_rd_cnt c=%0d got=%h exp=%h", c, rd_cnt, exp_rd); end
        end
        total++; if (rd_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_final got=%h exp=FFFFFFFF", rd_cnt); end
    endtask

    task automatic test_reset_priority();
        step(1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'hC0FF_EE01);
        step(1'b1, 1'b1, 4'hF, BASE + 32'h20, 32'h5A5A_5A5A);
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0);
`ifdef DSRAM_CLEAR_ON_RESET_EN
        repeat (DEPTH + 1) step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
`else
        step(1'b0, 1'b0, 4'h0, BASE, 32'h0);
`endif
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL rstpri_rdata got=%h exp=0", data_sram_rdata); end
        total++; if (rd_cnt !== 32'h0) begin bad++; $display("FAIL rstpri_rd got=%h exp=0", rd_cnt); end
        total++; if (wr_cnt !== 32'h0) begin bad++; $display("FAIL rstpri_wr got=%h exp=0", wr_cnt); end
        step(1'b0, 1'b1, 4'h0, BASE + 32'h20, 32'h0);
`ifdef DSRAM_CLEAR_ON_RESET_EN
        total++; if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL rstpri_old got=%h exp=0", data_sram_rdata); end
`else
        total++; if (data_sram_rdata !== 32'hC0FF_EE01) begin bad++; $display("FAIL rstpri_old got=%h exp=C0FFEE01", data_sram_rdata); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [3:0]  wen;
        int          r;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = BASE - 32'($urandom_range(1, 64));
            else if (r == 1) addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else             addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), wen, addr, $urandom);
            total++; if (data_sram_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, data_sram_rdata, exp_rdata); end
            total++; if (addr_err !== exp_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, addr_err, exp_err); end
            total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, rd_cnt, exp_rd); end
            total++; if (wr_cnt !== exp_wr) begin bad++; $display("FAIL rnd_wr n=%0d got=%0d exp=%0d", n, wr_cnt, exp_wr); end
            total++; if (sram_ready !== model_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, sram_ready, model_ready); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
        test_reset();
`ifdef DSRAM_CLEAR_ON_RESET_EN
        test_clear_sequence();
`endif
        test_full_word();
        test_byte_lanes();
        test_out_of_range();
        test_hold();
        test_saturate();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
